// File: rtl/mac_stat_pkg.sv
// rtl/mac_stat_pkg.sv - shared addresses, sizes and FSM encoding for the MAC statistics poller
// Contents: MAC statistics register word addresses, NUM_STATS, poller state_t, stat_addr() helper.
package mac_stat_pkg;

  localparam logic [7:0] STAT_TX_OK     = 8'h1A;
  localparam logic [7:0] STAT_RX_OK     = 8'h1B;
  localparam logic [7:0] STAT_FCS_ERR   = 8'h1C;
  localparam logic [7:0] STAT_ALIGN_ERR = 8'h1D;

  localparam int NUM_STATS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_GAP,
    ST_COMMIT,
    ST_ABORT
  } state_t;

  // Counters sit at consecutive word addresses starting at STAT_TX_OK.
  function automatic logic [7:0] stat_addr(input logic [1:0] idx);
    return STAT_TX_OK + {6'd0, idx};
  endfunction

endpackage

// File: rtl/mac_stat_timer.sv
// rtl/mac_stat_timer.sv - poll period counter with early start and terminal-count pulse
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count while high; the counter is held at zero while low
//   start      : request an immediate terminal count (only honoured while en)
//   tc         : combinational terminal-count pulse; the counter restarts from zero after it
module mac_stat_timer #(
  parameter int POLL_PERIOD = 1250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic start,
  output logic tc
);

  localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  logic [CW-1:0] count;

  assign tc = en && (start || (count == CW'(POLL_PERIOD - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en || tc) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mac_stat_poller.sv
// rtl/mac_stat_poller.sv - periodic Avalon-MM reader of MAC frame statistics with atomic snapshot
// Optional feature macro: MAC_STAT_DELTA_EN (adds per-counter delta outputs).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_done             : MAC configuration complete; poller idles while low
//   poll_req             : one-cycle request to start a round now (honoured only in WAIT)
//   address, read        : Avalon-MM master address / read strobe
//   readdata, waitrequest: Avalon-MM read data / wait request
//   tx_ok_cnt .. align_err_cnt : committed snapshot of the four counters
//   stat_valid           : one-cycle pulse when a snapshot is committed
//   bus_err              : sticky read-timeout flag, cleared only by reset
//   *_delta (optional)   : new snapshot minus previous snapshot, modulo 2^32
module mac_stat_poller
  import mac_stat_pkg::*;
#(
  parameter int POLL_PERIOD  = 1250000,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        poll_req,
  output logic [7:0]  address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [31:0] tx_ok_cnt,
  output logic [31:0] rx_ok_cnt,
  output logic [31:0] fcs_err_cnt,
  output logic [31:0] align_err_cnt,
  output logic        stat_valid,
  output logic        bus_err
`ifdef MAC_STAT_DELTA_EN
  ,
  output logic [31:0] tx_ok_delta,
  output logic [31:0] rx_ok_delta,
  output logic [31:0] fcs_err_delta,
  output logic [31:0] align_err_delta
`endif
);

  localparam int WW = ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;

  state_t         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [31:0]    shadow [NUM_STATS];
  logic           tc;
  logic           commit;

  mac_stat_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cfg_done && (state_q == ST_WAIT)),
    .start (poll_req),
    .tc    (tc)
  );

  // read is a pure state decode, so a cfg_done drop removes it one cycle later.
  assign read   = (state_q == ST_RD);
  // A round interrupted by cfg_done never publishes its shadow contents.
  assign commit = (state_q == ST_COMMIT) && cfg_done;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    if (!cfg_done) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_WAIT;
        ST_WAIT: begin
          if (tc) begin
            state_d = ST_RD;
            idx_d   = '0;
            wcnt_d  = '0;
          end
        end
        ST_RD: begin
          if (!waitrequest) begin
            state_d = ST_GAP;
          end else if (wcnt_q == WW'(WAIT_TIMEOUT - 1)) begin
            state_d = ST_ABORT;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
        ST_GAP: begin
          wcnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_RD;
          end
        end
        ST_COMMIT: state_d = ST_WAIT;
        ST_ABORT:  state_d = ST_WAIT;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      wcnt_q        <= '0;
      address       <= 8'h00;
      tx_ok_cnt     <= '0;
      rx_ok_cnt     <= '0;
      fcs_err_cnt   <= '0;
      align_err_cnt <= '0;
      stat_valid    <= 1'b0;
      bus_err       <= 1'b0;
      for (int i = 0; i < NUM_STATS; i++) begin
        shadow[i] <= '0;
      end
`ifdef MAC_STAT_DELTA_EN
      tx_ok_delta     <= '0;
      rx_ok_delta     <= '0;
      fcs_err_delta   <= '0;
      align_err_delta <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      stat_valid <= commit;

      // Address is loaded only on RD entry, so it is stable through
      // waitrequest and holds its last value between reads.
      if (state_d == ST_RD) begin
        address <= stat_addr(idx_d);
      end

      if ((state_q == ST_RD) && !waitrequest) begin
        shadow[idx_q] <= readdata;
      end

      if (commit) begin
        tx_ok_cnt     <= shadow[0];
        rx_ok_cnt     <= shadow[1];
        fcs_err_cnt   <= shadow[2];
        align_err_cnt <= shadow[3];
`ifdef MAC_STAT_DELTA_EN
        // Unsigned wrap of the subtraction matches MAC counter rollover.
        tx_ok_delta     <= shadow[0] - tx_ok_cnt;
        rx_ok_delta     <= shadow[1] - rx_ok_cnt;
        fcs_err_delta   <= shadow[2] - fcs_err_cnt;
        align_err_delta <= shadow[3] - align_err_cnt;
`endif
      end

      if (state_q == ST_ABORT) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_stat_poller.sv
// tb/tb_mac_stat_poller.sv - directed self-checking bench for mac_stat_poller
module tb_mac_stat_poller;

  localparam int POLL_PERIOD  = 16;
  localparam int WAIT_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_done;
  logic        poll_req;
  logic [7:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] tx_ok_cnt, rx_ok_cnt, fcs_err_cnt, align_err_cnt;
  logic        stat_valid;
  logic        bus_err;
`ifdef MAC_STAT_DELTA_EN
  logic [31:0] tx_ok_delta, rx_ok_delta, fcs_err_delta, align_err_delta;
`endif

  logic [31:0] mem [4];
  logic        garble;
  logic [7:0]  rd_off;

  logic [31:0] exp_tx, exp_rx, exp_fcs, exp_align;

  int checks   = 0;
  int failures = 0;

  mac_stat_poller #(
    .POLL_PERIOD  (POLL_PERIOD),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_done      (cfg_done),
    .poll_req      (poll_req),
    .address       (address),
    .read          (read),
    .readdata      (readdata),
    .waitrequest   (waitrequest),
    .tx_ok_cnt     (tx_ok_cnt),
    .rx_ok_cnt     (rx_ok_cnt),
    .fcs_err_cnt   (fcs_err_cnt),
    .align_err_cnt (align_err_cnt),
    .stat_valid    (stat_valid),
    .bus_err       (bus_err)
`ifdef MAC_STAT_DELTA_EN
    ,
    .tx_ok_delta     (tx_ok_delta),
    .rx_ok_delta     (rx_ok_delta),
    .fcs_err_delta   (fcs_err_delta),
    .align_err_delta (align_err_delta)
`endif
  );

  always #5 clk = ~clk;

  // MAC register file model; data is corrupted while the bench stalls the bus.
  always_comb begin
    rd_off   = address - 8'h1A;
    readdata = 32'hBAD0_BAD0;
    if (address >= 8'h1A && address <= 8'h1D) readdata = mem[rd_off[1:0]];
    if (garble) readdata = readdata ^ 32'hDEAD_0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_read(input int bound, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < bound) begin
      @(negedge clk);
      n++;
      if (read === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input int bound, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < bound) begin
      @(negedge clk);
      n++;
      if (stat_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_done = 1'b0; poll_req = 1'b0; waitrequest = 1'b0; garble = 1'b0;
    mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (read !== 1'b0 || stat_valid !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got read=%b stat_valid=%b bus_err=%b expected 0 0 0", read, stat_valid, bus_err);
    end
    checks++;
    if (address !== 8'h00) begin
      failures++;
      $display("FAIL reset_address: got %h expected 00", address);
    end
    checks++;
    if ({tx_ok_cnt, rx_ok_cnt, fcs_err_cnt, align_err_cnt} !== 128'h0) begin
      failures++;
      $display("FAIL reset_counters: got %h %h %h %h expected all 0", tx_ok_cnt, rx_ok_cnt, fcs_err_cnt, align_err_cnt);
    end
`ifdef MAC_STAT_DELTA_EN
    checks++;
    if ({tx_ok_delta, rx_ok_delta, fcs_err_delta, align_err_delta} !== 128'h0) begin
      failures++;
      $display("FAIL reset_deltas: got %h %h %h %h expected all 0", tx_ok_delta, rx_ok_delta, fcs_err_delta, align_err_delta);
    end
`endif
    rst_n = 1'b1;
    exp_tx = '0; exp_rx = '0; exp_fcs = '0; exp_align = '0;
  endtask

  task automatic test_idle();
    int rd_seen, sv_seen;
    rd_seen = 0;
    sv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (read !== 1'b0) rd_seen++;
      if (stat_valid !== 1'b0) sv_seen++;
    end
    checks++;
    if (rd_seen != 0 || sv_seen != 0) begin
      failures++;
      $display("FAIL idle_quiet: got read_cycles=%0d valid_cycles=%0d expected 0 0", rd_seen, sv_seen);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    int n, bad;
    logic exp_rd;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    cfg_done = 1'b1;
    wait_read(40, ok, n);
    checks++;
    if (!ok || n != 17) begin
      failures++;
      $display("FAIL nominal_first_read: got ok=%0d cycles=%0d expected ok=1 cycles=17", ok, n);
    end
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      exp_rd = (i % 2 == 0) && (i < 8);
      if (read !== exp_rd) bad++;
      if (i < 8 && address !== 8'(8'h1A + i / 2)) bad++;
      if (stat_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL nominal_sequence: got %0d bad cycles expected 0", bad);
    end
    @(negedge clk);
    checks++;
    if (stat_valid !== 1'b1) begin
      failures++;
      $display("FAIL nominal_valid_latency: got stat_valid=%b expected 1 at 9 cycles", stat_valid);
    end
    checks++;
    if (tx_ok_cnt !== 32'h11 || rx_ok_cnt !== 32'h22 || fcs_err_cnt !== 32'h33 || align_err_cnt !== 32'h44) begin
      failures++;
      $display("FAIL nominal_snapshot: got %h %h %h %h expected 11 22 33 44", tx_ok_cnt, rx_ok_cnt, fcs_err_cnt, align_err_cnt);
    end
`ifdef MAC_STAT_DELTA_EN
    checks++;
    if (tx_ok_delta !== 32'h11 || align_err_delta !== 32'h44) begin
      failures++;
      $display("FAIL first_delta: got tx=%h align=%h expected 11 44", tx_ok_delta, align_err_delta);
    end
`endif
    @(negedge clk);
    checks++;
    if (stat_valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_valid_pulse: got stat_valid=%b expected 0", stat_valid);
    end
    exp_tx = 32'h11; exp_rx = 32'h22; exp_fcs = 32'h33; exp_align = 32'h44;
  endtask

  task automatic test_poll_req();
    bit ok;
    int n;
    // Entered one cycle into WAIT (count 1); two more cycles reach count 3.
    repeat (2) @(negedge clk);
    checks++;
    if (read !== 1'b0) begin
      failures++;
      $display("FAIL poll_pre: got read=%b expected 0", read);
    end
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    checks++;
    if (read !== 1'b1 || address !== 8'h1A) begin
      failures++;
      $display("FAIL poll_early: got read=%b address=%h expected 1 1a", read, address);
    end
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    wait_valid(20, ok, n);
    checks++;
    if (!ok || n != 8) begin
      failures++;
      $display("FAIL poll_in_rd_ignored: got ok=%0d cycles=%0d expected ok=1 cycles=8", ok, n);
    end
    wait_read(40, ok, n);
    checks++;
    if (!ok || n != 16) begin
      failures++;
      $display("FAIL poll_no_queue: got ok=%0d cycles=%0d expected ok=1 cycles=16", ok, n);
    end
    wait_valid(20, ok, n);
  endtask

  task automatic test_stall();
    bit ok;
    int n, bad;
    mem[0] = 32'h101; mem[1] = 32'h202; mem[2] = 32'h303; mem[3] = 32'h404;
    wait_read(40, ok, n);
    @(negedge clk);
    waitrequest = 1'b1;
    garble      = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (read !== 1'b1 || address !== 8'h1B) bad++;
    end
    waitrequest = 1'b0;
    garble      = 1'b0;
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL stall_stable: got ok=%0d bad_cycles=%0d expected ok=1 bad_cycles=0", ok, bad);
    end
    @(negedge clk);
    checks++;
    if (read !== 1'b0) begin
      failures++;
      $display("FAIL stall_gap: got read=%b expected 0", read);
    end
    wait_valid(20, ok, n);
    checks++;
    if (!ok || n != 6) begin
      failures++;
      $display("FAIL stall_latency: got ok=%0d cycles=%0d expected ok=1 cycles=6", ok, n);
    end
    checks++;
    if (tx_ok_cnt !== 32'h101 || rx_ok_cnt !== 32'h202 || fcs_err_cnt !== 32'h303 || align_err_cnt !== 32'h404) begin
      failures++;
      $display("FAIL stall_capture: got %h %h %h %h expected 101 202 303 404", tx_ok_cnt, rx_ok_cnt, fcs_err_cnt, align_err_cnt);
    end
    exp_tx = 32'h101; exp_rx = 32'h202; exp_fcs = 32'h303; exp_align = 32'h404;
  endtask

  task automatic test_timeout();
    bit ok;
    int n, hi, sv;
    waitrequest = 1'b1;
    wait_read(40, ok, n);
    hi = ok ? 1 : 0;
    sv = 0;
    for (int i = 0; i < 20 && ok; i++) begin
      @(negedge clk);
      if (stat_valid !== 1'b0) sv++;
      if (read === 1'b1) hi++;
      else break;
    end
    checks++;
    if (hi != 8) begin
      failures++;
      $display("FAIL timeout_len: got read_cycles=%0d expected 8", hi);
    end
    @(negedge clk);
    if (stat_valid !== 1'b0) sv++;
    waitrequest = 1'b0;
    checks++;
    if (bus_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_bus_err: got %b expected 1", bus_err);
    end
    checks++;
    if (sv != 0 || tx_ok_cnt !== exp_tx || rx_ok_cnt !== exp_rx || fcs_err_cnt !== exp_fcs || align_err_cnt !== exp_align) begin
      failures++;
      $display("FAIL timeout_no_partial: got valid=%0d %h %h %h %h expected 0 %h %h %h %h",
               sv, tx_ok_cnt, rx_ok_cnt, fcs_err_cnt, align_err_cnt, exp_tx, exp_rx, exp_fcs, exp_align);
    end
    mem[0] = 32'h555; mem[1] = 32'h666; mem[2] = 32'h777; mem[3] = 32'h888;
    wait_read(40, ok, n);
    checks++;
    if (!ok || n != 16) begin
      failures++;
      $display("FAIL timeout_next_period: got ok=%0d cycles=%0d expected ok=1 cycles=16", ok, n);
    end
    wait_valid(20, ok, n);
    checks++;
    if (!ok || n != 9 || tx_ok_cnt !== 32'h555 || align_err_cnt !== 32'h888) begin
      failures++;
      $display("FAIL timeout_recover: got ok=%0d cycles=%0d tx=%h align=%h expected 1 9 555 888", ok, n, tx_ok_cnt, align_err_cnt);
    end
    checks++;
    if (bus_err !== 1'b1) begin
      failures++;
      $display("FAIL bus_err_sticky: got %b expected 1", bus_err);
    end
    exp_tx = 32'h555; exp_rx = 32'h666; exp_fcs = 32'h777; exp_align = 32'h888;
  endtask

`ifdef MAC_STAT_DELTA_EN
  task automatic test_delta();
    bit ok;
    int n;
    mem[0] = 32'hFFFF_FFF0; mem[1] = 32'h100;
    wait_valid(60, ok, n);
    mem[0] = 32'h0000_0010; mem[1] = 32'h150;
    wait_valid(60, ok, n);
    checks++;
    if (!ok || tx_ok_delta !== 32'h20 || rx_ok_delta !== 32'h50 || fcs_err_delta !== 32'h0 || align_err_delta !== 32'h0) begin
      failures++;
      $display("FAIL delta_wrap: got ok=%0d %h %h %h %h expected 1 20 50 0 0",
               ok, tx_ok_delta, rx_ok_delta, fcs_err_delta, align_err_delta);
    end
    exp_tx = 32'h10; exp_rx = 32'h150;
  endtask
`endif

  task automatic test_cfg_drop();
    bit ok;
    int n, rd_seen, sv_seen;
    wait_read(40, ok, n);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || read !== 1'b1 || address !== 8'h1B) begin
      failures++;
      $display("FAIL drop_setup: got ok=%0d read=%b address=%h expected 1 1 1b", ok, read, address);
    end
    cfg_done = 1'b0;
    @(negedge clk);
    checks++;
    if (read !== 1'b0) begin
      failures++;
      $display("FAIL drop_read: got read=%b expected 0", read);
    end
    rd_seen = 0;
    sv_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (read !== 1'b0) rd_seen++;
      if (stat_valid !== 1'b0) sv_seen++;
    end
    checks++;
    if (rd_seen != 0 || sv_seen != 0) begin
      failures++;
      $display("FAIL drop_quiet: got read_cycles=%0d valid_cycles=%0d expected 0 0", rd_seen, sv_seen);
    end
    checks++;
    if (tx_ok_cnt !== exp_tx || rx_ok_cnt !== exp_rx || fcs_err_cnt !== exp_fcs || align_err_cnt !== exp_align || bus_err !== 1'b1) begin
      failures++;
      $display("FAIL drop_retained: got %h %h %h %h bus_err=%b expected %h %h %h %h 1",
               tx_ok_cnt, rx_ok_cnt, fcs_err_cnt, align_err_cnt, bus_err, exp_tx, exp_rx, exp_fcs, exp_align);
    end
    cfg_done = 1'b1;
    wait_read(40, ok, n);
    checks++;
    if (!ok || n != 17 || address !== 8'h1A) begin
      failures++;
      $display("FAIL drop_restart: got ok=%0d cycles=%0d address=%h expected 1 17 1a", ok, n, address);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_nominal();
    test_poll_req();
    test_stall();
    test_timeout();
`ifdef MAC_STAT_DELTA_EN
    test_delta();
`endif
    test_cfg_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
